// File: rtl/mna_stamp_builder.sv
// mna_stamp_builder: accumulates R/V/I element stamps into an MNA matrix A and vector b, then starts a solver
// Ports: clk, I_RST (async, active-high); clr starts a new netlist; elem_* is a valid/ready element stream
// (type 0 R conductance, 1 V source volts with branch row k, 2 I source amps); commit ends the netlist;
// A/b are the accumulated system; solve_start/solve_ready handshake with the solver; busy, done, err status.
// Define STAMP_SATURATE_EN to saturate accumulations (and flag err) instead of wrapping.
module mna_stamp_builder #(
  parameter int SIZE = 3,
  parameter int PRECISION = 32,
  parameter int POINT = 16,
  parameter int NODE_W = $clog2(SIZE+1),
  localparam int W = PRECISION + POINT
) (
  input  logic                             clk,
  input  logic                             I_RST,
  input  logic                             clr,
  input  logic                             elem_valid,
  output logic                             elem_ready,
  input  logic [1:0]                       elem_type,
  input  logic [NODE_W-1:0]                elem_p,
  input  logic [NODE_W-1:0]                elem_n,
  input  logic [NODE_W-1:0]                elem_k,
  input  logic [W-1:0]                     elem_val,
  input  logic                             commit,
  output logic [SIZE-1:0][SIZE-1:0][W-1:0] A,
  output logic [SIZE-1:0][W-1:0]           b,
  output logic                             solve_start,
  input  logic                             solve_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, LOAD = 3'd2, STAMP = 3'd3, START = 3'd4, WAIT = 3'd5, DONE = 3'd6;
  localparam logic [NODE_W-1:0] GND = NODE_W'(SIZE);
  localparam logic [W-1:0] ONE = W'(1) << POINT;
  logic [2:0] state, nstate, step;
  logic [1:0] t;
  logic [NODE_W-1:0] p, n, k, row, col;
  logic [W-1:0] val, delta, cur, nxt;
  logic pend, to_b, neg, last, skip, sat, accept, bad;
  assign elem_ready = state == LOAD;
  assign solve_start = state == START;
  assign busy = state != IDLE && state != DONE;
  assign accept = elem_ready && elem_valid;
  assign bad = elem_p > GND || elem_n > GND || elem_type == 2'd3 || (elem_type == 2'd1 && elem_k >= GND);
  // Per-step write target: R is pp,nn,pn,np; V is pk,kp,nk,kn then b[k]; I is b[p] then b[n].
  assign row = t == 2'd1 ? (step == 3'd4 || step[0] ? k : step[1] ? n : p) : (step[0] ? n : p);
  assign col = t == 2'd1 ? (step[0] ? (step[1] ? n : p) : k) : (step[0] ^ step[1] ? n : p);
  assign to_b = t == 2'd2 || (t == 2'd1 && step == 3'd4);
  assign neg = t == 2'd2 ? step[0] : step[1];
  assign delta = t == 2'd1 && step != 3'd4 ? ONE : val;
  assign last = t == 2'd0 ? step == 3'd3 : t == 2'd1 ? step == 3'd4 : step[0];
  // Ground row/column writes still take their cycle but change nothing.
  assign skip = row == GND || (!to_b && col == GND);
  always_comb begin
    cur = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (to_b && row == NODE_W'(i)) cur = b[i];
      for (int j = 0; j < SIZE; j++)
        if (!to_b && row == NODE_W'(i) && col == NODE_W'(j)) cur = A[i][j];
    end
  end
`ifdef STAMP_SATURATE_EN
  logic [W:0] ext;
  assign ext = neg ? {cur[W-1], cur} - {delta[W-1], delta} : {cur[W-1], cur} + {delta[W-1], delta};
  assign sat = ext[W] ^ ext[W-1];
  assign nxt = sat ? (ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : ext[W-1:0];
`else
  assign sat = 1'b0;
  assign nxt = neg ? cur - delta : cur + delta;
`endif
  always_comb begin
    nstate = state;
    case (state)
      IDLE, DONE: nstate = clr ? CLEAR : state;
      CLEAR:      nstate = LOAD;
      LOAD:       nstate = accept && !bad ? STAMP : commit ? START : LOAD;
      STAMP:      nstate = last ? (pend ? START : LOAD) : STAMP;
      START:      nstate = WAIT;
      WAIT:       nstate = solve_ready ? DONE : WAIT;
      default:    nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state <= IDLE;
      step <= '0;
      t <= '0;
      p <= '0;
      n <= '0;
      k <= '0;
      val <= '0;
      pend <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      A <= '0;
      b <= '0;
    end else begin
      state <= nstate;
      done <= state == WAIT && solve_ready;
      // A new netlist also starts with a clean error flag.
      if (state == CLEAR) begin
        A <= '0;
        b <= '0;
        err <= 1'b0;
      end
      if (accept && bad) err <= 1'b1;
      if (accept && !bad) begin
        t <= elem_type;
        p <= elem_p;
        n <= elem_n;
        k <= elem_k;
        val <= elem_val;
        pend <= commit;
        step <= '0;
      end
      if (state == STAMP) begin
        step <= step + 3'd1;
        if (!skip) begin
          for (int i = 0; i < SIZE; i++) begin
            if (to_b && row == NODE_W'(i)) b[i] <= nxt;
            for (int j = 0; j < SIZE; j++)
              if (!to_b && row == NODE_W'(i) && col == NODE_W'(j)) A[i][j] <= nxt;
          end
          if (sat) err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mna_stamp_builder.sv
// tb_mna_stamp_builder: directed stimulus with a queued scoreboard checked at each solve_start
module tb_mna_stamp_builder;
  localparam int S = 3, W = 48, NW = 3;
  logic clk = 0, rst = 1, clr = 0, elem_valid = 0, commit = 0, solve_ready = 0;
  logic [1:0] elem_type = 0;
  logic [NW-1:0] elem_p = 0, elem_n = 0, elem_k = 0;
  logic [W-1:0] elem_val = 0;
  logic elem_ready, solve_start, busy, done, err;
  logic [S-1:0][S-1:0][W-1:0] A;
  logic [S-1:0][W-1:0] b;
  typedef struct packed {
    logic [S-1:0][S-1:0][W-1:0] a;
    logic [S-1:0][W-1:0] b;
    logic err;
    int start;
    int d;
  } exp_t;
  exp_t q[$];
  exp_t e, me;
  int vecs = 0, miss = 0, cyc = 0, starts = 0, ms, acc, s0;
  localparam logic [W-1:0] GMAX = 48'h7FFF_FFFF_FFFF;

  mna_stamp_builder #(.SIZE(S), .PRECISION(32), .POINT(16), .NODE_W(NW)) dut (
    .clk(clk), .I_RST(rst), .clr(clr), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_type(elem_type), .elem_p(elem_p), .elem_n(elem_n), .elem_k(elem_k), .elem_val(elem_val),
    .commit(commit), .A(A), .b(b), .solve_start(solve_start), .solve_ready(solve_ready),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(output int c);
    int t = 0;
    @(negedge clk);
    while (!elem_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!elem_ready) begin
      vecs++;
      miss++;
      $display("FAIL ready_timeout: elem_ready low for %0d cycles, want high", t);
    end
    c = cyc;
  endtask

  task automatic send(input logic [1:0] ty, input int pp, input int nn, input int kk,
                      input logic [W-1:0] v, input logic cm, output int a);
    wait_ready(a);
    elem_type = ty;
    elem_p = NW'(pp);
    elem_n = NW'(nn);
    elem_k = NW'(kk);
    elem_val = v;
    commit = cm;
    elem_valid = 1;
    @(negedge clk);
    elem_valid = 0;
    commit = 0;
  endtask

  task automatic do_commit(input exp_t x, input int st);
    int c;
    wait_ready(c);
    x.start = st < 0 ? c + 1 : st;
    q.push_back(x);
    commit = 1;
    @(negedge clk);
    commit = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy || q.size() != 0) begin
      vecs++;
      miss++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d, want 0 0", busy, q.size());
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (solve_start) begin
      ms = cyc;
      starts++;
      if (q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL unexpected_solve_start: got pulse at cycle %0d, want none", ms);
      end else begin
        me = q.pop_front();
        for (int i = 0; i < S; i++) begin
          for (int j = 0; j < S; j++) chk($sformatf("A[%0d][%0d]", i, j), A[i][j], me.a[i][j]);
          chk($sformatf("b[%0d]", i), b[i], me.b[i]);
        end
        chk("err", W'(err), W'(me.err));
        chk("start_cycle", W'(ms), W'(me.start));
        for (int c = 1; c <= me.d; c++) begin
          @(negedge clk);
          if (c == 1) chk("start_width", W'(solve_start), 0);
          chk("done_early", W'(done), 0);
          if (c == me.d) solve_ready = 1;
        end
        @(negedge clk);
        chk("done", W'(done), 1);
        chk("busy_done", W'(busy), 0);
        solve_ready = 0;
        @(negedge clk);
        chk("done_width", W'(done), 0);
      end
    end
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) chk("rst_A", A[i][j], 0);
      chk("rst_b", b[i], 0);
    end
    chk("rst_ready", W'(elem_ready), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_err", W'(err), 0);
    chk("rst_start", W'(solve_start), 0);
    rst = 0;

    // single resistor to ground, commit on its own
    pulse_clr();
    send(2'd0, 0, 3, 0, 48'd655, 0, acc);
    e = '0;
    e.a[0][0] = 48'd655;
    e.d = 1;
    do_commit(e, acc + 6);
    wait_idle();

    // two resistors and a voltage source; a stray clr mid-load is ignored
    pulse_clr();
    send(2'd0, 0, 1, 0, 48'd655, 0, acc);
    send(2'd0, 1, 3, 0, 48'd655, 0, acc);
    pulse_clr();
    send(2'd1, 0, 3, 2, 48'd786432, 0, acc);
    e = '0;
    e.a[0][0] = 48'd655;
    e.a[0][1] = -48'sd655;
    e.a[1][0] = -48'sd655;
    e.a[1][1] = 48'd1310;
    e.a[0][2] = 48'd65536;
    e.a[2][0] = 48'd65536;
    e.b[2] = 48'd786432;
    e.d = 3;
    do_commit(e, acc + 7);
    wait_idle();

    // current source with commit in the same cycle; solver slow to respond
    pulse_clr();
    e = '0;
    e.b[1] = 48'd65536;
    e.d = 4;
    send(2'd2, 1, 3, 0, 48'd65536, 1, acc);
    e.start = acc + 3;
    q.push_back(e);
    wait_idle();

    // malformed elements are dropped and flag err
    pulse_clr();
    send(2'd2, 0, 3, 0, 48'd1000, 0, acc);
    send(2'd0, 5, 0, 0, 48'd100, 0, acc);
    chk("drop_err", W'(err), 1);
    chk("drop_ready", W'(elem_ready), 1);
    send(2'd1, 0, 3, 3, 48'd5, 0, acc);
    send(2'd3, 0, 1, 0, 48'd7, 0, acc);
    e = '0;
    e.b[0] = 48'd1000;
    e.err = 1;
    e.d = 2;
    do_commit(e, -1);
    wait_idle();

    // reset during the third resistor stamp cycle abandons the stamp and its commit
    pulse_clr();
    send(2'd0, 0, 1, 0, 48'd500, 1, acc);
    @(negedge clk);
    @(negedge clk);
    s0 = starts;
    rst = 1;
    #1;
    chk("mid_rst_busy", W'(busy), 0);
    chk("mid_rst_ready", W'(elem_ready), 0);
    chk("mid_rst_A00", A[0][0], 0);
    chk("mid_rst_A11", A[1][1], 0);
    chk("mid_rst_A01", A[0][1], 0);
    chk("mid_rst_start", W'(solve_start), 0);
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    chk("no_start_after_rst", W'(starts), W'(s0));
    chk("idle_after_rst", W'(busy), 0);

    // overflow of a diagonal entry
    pulse_clr();
    send(2'd0, 0, 3, 0, GMAX, 0, acc);
    send(2'd0, 0, 3, 0, GMAX, 0, acc);
    e = '0;
`ifdef STAMP_SATURATE_EN
    e.a[0][0] = GMAX;
    e.err = 1;
`else
    e.a[0][0] = -48'sd2;
    e.err = 0;
`endif
    e.d = 1;
    do_commit(e, -1);
    wait_idle();

    // current source between two nodes plus a resistor off the ground node
    pulse_clr();
    send(2'd2, 0, 2, 0, 48'd300, 0, acc);
    send(2'd0, 2, 0, 0, 48'd10, 0, acc);
    e = '0;
    e.b[0] = 48'd300;
    e.b[2] = -48'sd300;
    e.a[2][2] = 48'd10;
    e.a[0][0] = 48'd10;
    e.a[2][0] = -48'sd10;
    e.a[0][2] = -48'sd10;
    e.d = 2;
    do_commit(e, -1);
    wait_idle();

    chk("scoreboard_empty", W'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/mna_stamp_builder.md
MNA_STAMP_BUILDER -- requirements
Module: mna_stamp_builder

Interface
REQ-001 SHALL have parameter SIZE, default 3, meaning matrix dimension (nodes plus voltage-source branches).
REQ-002 SHALL have parameter PRECISION, default 32, meaning integer bits of fixed-point values.
REQ-003 SHALL have parameter POINT, default 16, meaning fractional bits; the value width is W = PRECISION+POINT.
REQ-004 SHALL have parameter NODE_W, default $clog2(SIZE+1), meaning node-index width; the index value SIZE encodes ground.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; I_RST in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: clr in 1, pulse that starts a new netlist; elem_valid in 1; elem_ready out 1; elem_type in 2 (0 resistor, 1 voltage source, 2 current source, 3 reserved); elem_p, elem_n, elem_k in NODE_W; elem_val in W signed (conductance, volts or amps); commit in 1.
REQ-007 SHALL have ports: A out SIZE x SIZE x W signed; b out SIZE x W signed; solve_start out 1; solve_ready in 1; busy out 1; done out 1; err out 1.

Function
REQ-008 SHALL use states IDLE, CLEAR, LOAD, STAMP, START, WAIT, DONE.
REQ-009 SHALL go from IDLE or DONE to CLEAR on clr, and SHALL zero all of A and b in CLEAR in one cycle before entering LOAD.
REQ-010 SHALL drive elem_ready high only in LOAD, and SHALL accept an element on a cycle where elem_valid and elem_ready are both high.
REQ-011 SHALL apply a resistor stamp in exactly 4 STAMP cycles, one per cycle: A[p][p]+=G, A[n][n]+=G, A[p][n]-=G, A[n][p]-=G.
REQ-012 SHALL apply a voltage-source stamp in exactly 5 cycles: A[p][k]+=1.0, A[k][p]+=1.0, A[n][k]-=1.0, A[k][n]-=1.0, b[k]+=V.
REQ-013 SHALL apply a current-source stamp in exactly 2 cycles: b[p]+=I, then b[n]-=I.
REQ-014 SHALL suppress any write whose row or column index equals SIZE (ground) while still spending that write's cycle.
REQ-015 SHALL drop an element with any index above SIZE, a voltage-source k of SIZE or above, or type 3, without stamping, and SHALL set err sticky.
REQ-016 SHALL sample commit only while elem_ready is high; commit together with an accepted element SHALL be latched and acted on after that element's stamp completes.
REQ-017 SHALL pulse solve_start high for exactly one cycle in START, then hold WAIT for at least one cycle and until solve_ready is high.
REQ-018 SHALL pulse done for one cycle on entering DONE.
REQ-019 SHALL drive busy high in every state except IDLE and DONE.
REQ-020 SHALL hold A and b stable from START until clr.
REQ-021 SHALL ignore clr in states other than IDLE and DONE.
REQ-022 SHALL perform each accumulation as a W-bit signed add.

Reset
REQ-023 SHALL, on I_RST asynchronously, enter IDLE, zero A, b, solve_start, done and err, and drive elem_ready and busy low.
REQ-024 SHALL, on I_RST mid-stamp or mid-solve, abandon the partial stamp and any latched commit.

Configuration
REQ-025 SHALL, with STAMP_SATURATE_EN defined, saturate each accumulation to the signed W-bit max/min and set err on saturation; without it, accumulations SHALL wrap in two's complement and err SHALL not be set by overflow.

Verification
REQ-026 SHALL pass: clr; R 0-gnd(p=0, n=3, G=655); commit -> A[0][0]=655, all other A and b zero, and solve_start pulses 6 cycles after the accept.
REQ-027 SHALL pass: clr; R 0-1 G=655; R 1-gnd G=655; V p=0, n=3, k=2, 786432; commit -> A[0][0]=655, A[0][1]=A[1][0]=-655, A[1][1]=1310, A[0][2]=A[2][0]=65536, b[2]=786432, all others zero.
REQ-028 SHALL pass: I p=1, n=3, 65536 with commit in the same cycle -> b[1]=65536, commit honoured after 2 stamp cycles, done only after solve_ready is high.
REQ-029 SHALL pass: element with elem_p=5 -> dropped, err=1, A and b unchanged, elem_ready high again the next cycle.
REQ-030 SHALL pass: I_RST asserted during the third resistor stamp cycle -> IDLE immediately, A and b zero, no solve_start pulse.
REQ-031 SHALL pass: two R 0-gnd elements each with G=0x7FFF_FFFF_FFFF -> with STAMP_SATURATE_EN, A[0][0]=signed max and err=1; without it, A[0][0]=-2 and err=0.
